// File: rtl/ramz_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ramz_pingpong_ctrl
// Brief    : Two-bank ping-pong sequencer for a RAMZ block buffer; raster or
//            JPEG zigzag read order over valid/ready streams.
// Revision : 1.0
// ============================================================================
module ramz_pingpong_ctrl #(
  parameter int RAMADDR_W = 6,
  parameter int RAMDATA_W = 12,
  parameter int ZIGZAG    = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  input  logic [RAMDATA_W-1:0] wr_data,
  output logic                 wr_ready,
  output logic                 rd_valid,
  output logic [RAMDATA_W-1:0] rd_data,
  output logic                 rd_last,
  input  logic                 rd_ready,
  output logic [1:0]           bank_full,
  output logic [RAMDATA_W-1:0] ram_d,
  output logic [RAMADDR_W:0]   ram_waddr,
  output logic                 ram_we,
  output logic [RAMADDR_W:0]   ram_raddr,
  input  logic [RAMDATA_W-1:0] ram_q
);

  localparam logic [RAMADDR_W-1:0] C_LAST_IDX = {RAMADDR_W{1'b1}};

  logic [1:0]           r_full;
  logic [1:0]           w_full_nxt;
  logic                 r_wbank;
  logic                 r_ibank;
  logic                 r_obank;
  logic [RAMADDR_W-1:0] r_wr_idx;
  logic [RAMADDR_W-1:0] r_iss_idx;
  logic [RAMADDR_W-1:0] w_map;
  logic [RAMADDR_W:0]   r_cur_addr;
  logic [RAMADDR_W:0]   w_issue_addr;
  logic                 r_rd_valid;
  logic                 r_rd_last;
  logic                 w_wr_ready;
  logic                 w_wr_acc;
  logic                 w_wr_end;
  logic                 w_adv;
  logic                 w_iss_end;
  logic                 w_rd_fire;
  logic                 w_rd_end;

  // Block-index to RAM-offset mapping for the read side
  generate
    if (ZIGZAG != 0) begin : g_zigzag
      function automatic logic [5:0] zz_raster(input logic [5:0] k);
        logic [5:0] r;
        case (k)
          6'd0:  r = 6'd0;   6'd1:  r = 6'd1;   6'd2:  r = 6'd8;   6'd3:  r = 6'd16;
          6'd4:  r = 6'd9;   6'd5:  r = 6'd2;   6'd6:  r = 6'd3;   6'd7:  r = 6'd10;
          6'd8:  r = 6'd17;  6'd9:  r = 6'd24;  6'd10: r = 6'd32;  6'd11: r = 6'd25;
          6'd12: r = 6'd18;  6'd13: r = 6'd11;  6'd14: r = 6'd4;   6'd15: r = 6'd5;
          6'd16: r = 6'd12;  6'd17: r = 6'd19;  6'd18: r = 6'd26;  6'd19: r = 6'd33;
          6'd20: r = 6'd40;  6'd21: r = 6'd48;  6'd22: r = 6'd41;  6'd23: r = 6'd34;
          6'd24: r = 6'd27;  6'd25: r = 6'd20;  6'd26: r = 6'd13;  6'd27: r = 6'd6;
          6'd28: r = 6'd7;   6'd29: r = 6'd14;  6'd30: r = 6'd21;  6'd31: r = 6'd28;
          6'd32: r = 6'd35;  6'd33: r = 6'd42;  6'd34: r = 6'd49;  6'd35: r = 6'd56;
          6'd36: r = 6'd57;  6'd37: r = 6'd50;  6'd38: r = 6'd43;  6'd39: r = 6'd36;
          6'd40: r = 6'd29;  6'd41: r = 6'd22;  6'd42: r = 6'd15;  6'd43: r = 6'd23;
          6'd44: r = 6'd30;  6'd45: r = 6'd37;  6'd46: r = 6'd44;  6'd47: r = 6'd51;
          6'd48: r = 6'd58;  6'd49: r = 6'd59;  6'd50: r = 6'd52;  6'd51: r = 6'd45;
          6'd52: r = 6'd38;  6'd53: r = 6'd31;  6'd54: r = 6'd39;  6'd55: r = 6'd46;
          6'd56: r = 6'd53;  6'd57: r = 6'd60;  6'd58: r = 6'd61;  6'd59: r = 6'd54;
          6'd60: r = 6'd47;  6'd61: r = 6'd55;  6'd62: r = 6'd62;  default: r = 6'd63;
        endcase
        return r;
      endfunction
      assign w_map = RAMADDR_W'(zz_raster(6'(r_iss_idx)));
    end else begin : g_raster
      assign w_map = r_iss_idx;
    end
  endgenerate

  assign w_wr_ready   = ~r_full[r_wbank];
  assign w_wr_acc     = wr_valid & w_wr_ready;
  assign w_wr_end     = w_wr_acc & (r_wr_idx == C_LAST_IDX);
  assign w_adv        = r_full[r_ibank] & (~r_rd_valid | rd_ready);
  assign w_iss_end    = (r_iss_idx == C_LAST_IDX);
  assign w_issue_addr = {r_ibank, w_map};
  assign w_rd_fire    = r_rd_valid & rd_ready;
  assign w_rd_end     = w_rd_fire & r_rd_last;

  assign wr_ready  = w_wr_ready;
  assign ram_we    = w_wr_acc;
  assign ram_d     = wr_data;
  assign ram_waddr = {r_wbank, r_wr_idx};
  // Holding the presented address during a stall keeps ram_q stable
  assign ram_raddr = w_adv ? w_issue_addr : r_cur_addr;
  assign rd_valid  = r_rd_valid;
  assign rd_last   = r_rd_last;
  assign rd_data   = ram_q;
  assign bank_full = r_full;

  // Set and clear always target different banks, so both may apply together
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_end) begin
      w_full_nxt[r_wbank] = 1'b1;
    end
    if (w_rd_end) begin
      w_full_nxt[r_obank] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      r_full <= w_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbank  <= 1'b0;
      r_wr_idx <= '0;
    end else if (w_wr_acc) begin
      r_wr_idx <= r_wr_idx + 1'b1;
      if (w_wr_end) begin
        r_wbank <= ~r_wbank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ibank    <= 1'b0;
      r_iss_idx  <= '0;
      r_cur_addr <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else if (w_adv) begin
      r_cur_addr <= w_issue_addr;
      r_rd_valid <= 1'b1;
      r_rd_last  <= w_iss_end;
      r_iss_idx  <= r_iss_idx + 1'b1;
      if (w_iss_end) begin
        r_ibank <= ~r_ibank;
      end
    end else if (w_rd_fire) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_obank <= 1'b0;
    end else if (w_rd_end) begin
      r_obank <= ~r_obank;
    end
  end

endmodule
`default_nettype wire
